// File: rtl/vram_write_arbiter_if.sv
// Client-side request/data bundle and memory-port outputs of the VRAM write arbiter.
// The arbiter drives the memory port, so it takes the master modport.
interface vram_write_arbiter_if #(
  parameter int unsigned ADDR_BITS  = 15,
  parameter int unsigned COLOR_BITS = 3
);
  logic [2:0]              req;
  logic [3*ADDR_BITS-1:0]  client_address;
  logic [3*COLOR_BITS-1:0] client_color;
  logic [2:0]              client_print_enable;
  logic [2:0]              grant;
  logic [ADDR_BITS-1:0]    address;
  logic [COLOR_BITS-1:0]   color;
  logic                    print_enable;
  logic                    busy;
  logic                    timeout_pulse;

  modport master (
    input  req, client_address, client_color, client_print_enable,
    output grant, address, color, print_enable, busy, timeout_pulse
  );

  modport slave (
    output req, client_address, client_color, client_print_enable,
    input  grant, address, color, print_enable, busy, timeout_pulse
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Round-robin, job-granular owner of the single VRAM write port for three painting
// clients, with a hold-time watchdog that revokes a stuck owner.
module vram_write_arbiter #(
  parameter int unsigned ADDR_BITS  = 15,
  parameter int unsigned COLOR_BITS = 3,
  parameter logic [15:0] MAX_HOLD   = 16'd50000
) (
  input logic                  Clck,
  input logic                  Reset,
  vram_write_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e                state_q, state_d;
  logic [2:0]            grant_q, grant_d;
  logic [2:0]            mask_q, mask_d;
  logic [1:0]            last_q, last_d;
  logic [15:0]           hold_q, hold_d;
  logic [ADDR_BITS-1:0]  address_q, address_d;
  logic [COLOR_BITS-1:0] color_q, color_d;
  logic                  pe_q, pe_d;
  logic                  timeout_q, timeout_d;

  logic [ADDR_BITS-1:0]  cl_addr  [3];
  logic [COLOR_BITS-1:0] cl_color [3];
  logic [2:0]            eligible;
  logic                  found;
  logic [1:0]            choice, cand;
  logic                  owner_req, expired;

  for (genvar g = 0; g < 3; g++) begin : g_unpack
    assign cl_addr[g]  = bus.client_address[g*ADDR_BITS +: ADDR_BITS];
    assign cl_color[g] = bus.client_color[g*COLOR_BITS +: COLOR_BITS];
  end

  assign eligible  = bus.req & ~mask_q;
  // In StOwn, last_q is the current owner.
  assign owner_req = bus.req[last_q];
  assign expired   = (MAX_HOLD != 16'd0) && (hold_q == MAX_HOLD - 16'd1);

  // Scan starts just after the previous owner, so it gets lowest priority.
  always_comb begin
    found  = 1'b0;
    choice = last_q;
    cand   = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      cand = 2'((int'(last_q) + i) % 3);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        choice = cand;
      end
    end
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StGap: state_d = found ? StOwn : StIdle;
      StOwn:         state_d = (!owner_req || expired) ? StGap : StOwn;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    last_d    = last_q;
    hold_d    = hold_q;
    address_d = address_q;
    color_d   = color_q;
    pe_d      = 1'b0;
    timeout_d = 1'b0;
    mask_d    = mask_q & bus.req;
    unique case (state_q)
      StIdle, StGap: begin
        if (found) begin
          grant_d = 3'b001 << choice;
          last_d  = choice;
          hold_d  = 16'd0;
        end else begin
          grant_d = 3'b000;
        end
      end
      StOwn: begin
        address_d = cl_addr[last_q];
        color_d   = cl_color[last_q];
        if (!owner_req) begin
          grant_d = 3'b000;
        end else if (expired) begin
          grant_d        = 3'b000;
          mask_d[last_q] = 1'b1;
          timeout_d      = 1'b1;
        end else begin
          pe_d = bus.client_print_enable[last_q];
          if (hold_q != 16'hFFFF) begin
            hold_d = hold_q + 16'd1;
          end
        end
      end
      default: grant_d = 3'b000;
    endcase
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      grant_q   <= 3'b000;
      mask_q    <= 3'b000;
      last_q    <= 2'd2;
      hold_q    <= 16'd0;
      address_q <= '0;
      color_q   <= '0;
      pe_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      mask_q    <= mask_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      address_q <= address_d;
      color_q   <= color_d;
      pe_q      <= pe_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.address       = address_q;
  assign bus.color         = color_q;
  assign bus.print_enable  = pe_q;
  assign bus.busy          = |grant_q;
  assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed scenarios followed by random traffic, all checked every cycle against a
// job-level model of the arbiter (owner / last / mask / hold count).
module tb_vram_write_arbiter;

  localparam int Hold = 8;

  logic        Clck = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  req_v = 3'b000;
  logic [2:0]  cpe = 3'b000;
  logic [14:0] ca [3];
  logic [2:0]  cc [3];

  int n_cmp = 0;
  int n_bad = 0;

  int          m_owner;
  int          m_last;
  int          m_hold;
  logic [2:0]  m_mask;
  logic [14:0] m_addr;
  logic [2:0]  m_color;
  logic        m_pe;
  logic        m_to;

  vram_write_arbiter_if #(.ADDR_BITS(15), .COLOR_BITS(3)) bus ();

  vram_write_arbiter #(
    .ADDR_BITS (15),
    .COLOR_BITS(3),
    .MAX_HOLD  (16'd8)
  ) dut (
    .Clck (Clck),
    .Reset(Reset),
    .bus  (bus)
  );

  assign bus.req                 = req_v;
  assign bus.client_address      = {ca[2], ca[1], ca[0]};
  assign bus.client_color        = {cc[2], cc[1], cc[0]};
  assign bus.client_print_enable = cpe;

  always #5 Clck = ~Clck;

  function automatic logic [2:0] exp_grant();
    if (m_owner < 0) return 3'b000;
    return 3'(3'b001 << m_owner);
  endfunction

  // One clock of the arbiter, described as jobs: who owns the port and why it ends.
  task automatic model_step();
    logic [2:0] elig;
    logic [2:0] new_mask;
    if (Reset) begin
      m_owner = -1; m_last = 2; m_hold = 0; m_mask = 3'b000;
      m_addr = '0; m_color = '0; m_pe = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      m_pe = 1'b0;
      new_mask = m_mask & req_v;
      if (m_owner < 0) begin
        elig = req_v & ~m_mask;
        for (int s = 1; s <= 3; s++) begin
          int c;
          c = (m_last + s) % 3;
          if (elig[c] && m_owner < 0) begin
            m_owner = c;
            m_last  = c;
            m_hold  = 0;
          end
        end
      end else begin
        m_addr  = ca[m_owner];
        m_color = cc[m_owner];
        if (!req_v[m_owner]) begin
          m_owner = -1;
        end else if (m_hold == Hold - 1) begin
          new_mask[m_owner] = 1'b1;
          m_to    = 1'b1;
          m_owner = -1;
        end else begin
          m_pe   = cpe[m_owner];
          m_hold = m_hold + 1;
        end
      end
      m_mask = new_mask;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clck);
    #1;
    model_step();
    check("grant", 32'(bus.grant), 32'(exp_grant()));
    check("address", 32'(bus.address), 32'(m_addr));
    check("color", 32'(bus.color), 32'(m_color));
    check("print_enable", 32'(bus.print_enable), 32'(m_pe));
    check("busy", 32'(bus.busy), 32'(exp_grant() != 3'b000));
    check("timeout_pulse", 32'(bus.timeout_pulse), 32'(m_to));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
  endtask

  initial begin
    logic [2:0] rr_exp [4];
    int hi_cnt;
    int pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      ca[i] = '0;
      cc[i] = '0;
    end
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    // Reset, then a single request from client 1.
    do_reset();
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_address", 32'(bus.address), 32'h0);
    check("rst_timeout", 32'(bus.timeout_pulse), 32'h0);
    cyc();
    req_v = 3'b010;
    cyc();
    check("single_grant", 32'(bus.grant), 32'h2);
    ca[1] = 15'h1234; cc[1] = 3'd6; cpe = 3'b010;
    cyc();
    check("single_addr", 32'(bus.address), 32'h1234);
    check("single_pe", 32'(bus.print_enable), 32'h1);
    req_v = 3'b000; cpe = 3'b000;
    cyc();
    check("single_release", 32'(bus.grant), 32'h0);
    cyc();

    // Round-robin with each owner releasing after four grant cycles.
    do_reset();
    req_v = 3'b111;
    cyc();
    for (int g = 0; g < 4; g++) begin
      check("rr_order", 32'(bus.grant), 32'(rr_exp[g]));
      repeat (3) cyc();
      req_v = 3'b111 & ~rr_exp[g];
      cyc();
      check("rr_gap", 32'(bus.grant), 32'h0);
      req_v = 3'b111;
      cyc();
    end
    req_v = 3'b000;
    cyc();

    // Isolation: client 2 wiggles while client 0 owns.
    do_reset();
    ca[0] = 15'h0ABC; cc[0] = 3'd5; cpe = 3'b001; req_v = 3'b001;
    cyc();
    for (int i = 0; i < 6; i++) begin
      ca[2]  = 15'($urandom);
      cpe[2] = ~cpe[2];
      cyc();
      check("iso_addr", 32'(bus.address), 32'h0ABC);
      check("iso_pe", 32'(bus.print_enable), 32'h1);
    end
    req_v = 3'b000; cpe = 3'b000;
    cyc();

    // Watchdog revokes client 1 after exactly eight grant cycles.
    do_reset();
    req_v = 3'b010;
    cyc();
    hi_cnt = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      if (bus.grant == 3'b010) hi_cnt++;
      if (bus.timeout_pulse) pulse_cnt++;
      cyc();
    end
    check("wd_grant_len", 32'(hi_cnt), 32'd8);
    check("wd_pulses", 32'(pulse_cnt), 32'd1);
    check("wd_masked", 32'(bus.grant), 32'h0);
    req_v = 3'b000;
    cyc();
    req_v = 3'b010;
    cyc();
    check("wd_regrant", 32'(bus.grant), 32'h2);
    req_v = 3'b000;
    cyc();

    // Drop in the eighth grant cycle is a normal release.
    do_reset();
    req_v = 3'b001;
    cyc();
    repeat (7) cyc();
    req_v = 3'b000;
    cyc();
    check("drop_exp_pulse", 32'(bus.timeout_pulse), 32'h0);
    check("drop_exp_grant", 32'(bus.grant), 32'h0);
    req_v = 3'b001;
    cyc();
    check("drop_exp_nomask", 32'(bus.grant), 32'h1);
    req_v = 3'b000;
    cyc();

    // Reset in the middle of client 2's job.
    do_reset();
    req_v = 3'b100; ca[2] = 15'h7FFF; cc[2] = 3'd7; cpe = 3'b100;
    cyc();
    cyc();
    check("mid_pe_before", 32'(bus.print_enable), 32'h1);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    check("mid_grant", 32'(bus.grant), 32'h0);
    check("mid_pe", 32'(bus.print_enable), 32'h0);
    check("mid_addr", 32'(bus.address), 32'h0);
    req_v = 3'b101;
    cyc();
    check("mid_first", 32'(bus.grant), 32'h1);
    req_v = 3'b000; cpe = 3'b000;
    cyc();

    // Random traffic with sticky requests so the watchdog fires now and then.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 9) == 0) req_v[i] = ~req_v[i];
        ca[i]  = 15'($urandom);
        cc[i]  = 3'($urandom);
        cpe[i] = 1'($urandom);
      end
      Reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
